// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared defaults and helpers for the clk_div_bank channel divider
package clkdiv_pkg;

  localparam int   DEF_DIV_DFLT  = 24999;
  localparam logic IDLE_LVL_DFLT = 1'b1;

  function automatic int sel_w(input int ch);
    return (ch <= 1) ? 1 : $clog2(ch);
  endfunction

endpackage

// File: rtl/clkdiv_ch.sv
// rtl/clkdiv_ch.sv - one divider channel: counter, active/shadow terminal, tick and square wave
module clkdiv_ch import clkdiv_pkg::*; #(
  parameter int   CW       = 16,
  parameter int   DEF_DIV  = DEF_DIV_DFLT,
  parameter logic IDLE_LVL = IDLE_LVL_DFLT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          sync_i,
  input  logic          wr_i,
  input  logic [CW-1:0] wr_data_i,
  output logic          tick_o,
  output logic          clk_out_o,
  output logic          pending_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] term_q, term_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          tick_q, tick_d;
  logic          clk_out_q, clk_out_d;

  always_comb begin
    cnt_d     = cnt_q;
    term_d    = term_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    tick_d    = tick_q;
    clk_out_d = clk_out_q;
    if (sync_i || !en_i) begin
      cnt_d     = '0;
      tick_d    = 1'b0;
      clk_out_d = IDLE_LVL;
      if (pending_q) begin
        term_d    = shadow_q;
        pending_d = 1'b0;
      end
      if (wr_i) begin
        shadow_d = wr_data_i;
        // A stopped channel has no terminal count to wait for, so the new value goes live at once.
        if (sync_i) pending_d = 1'b1;
        else        term_d    = wr_data_i;
      end
    end else begin
      if (cnt_q >= term_q) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
        if (pending_q) begin
          term_d    = shadow_q;
          pending_d = 1'b0;
        end
      end else begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
      end
      if (wr_i) begin
        shadow_d  = wr_data_i;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      term_q    <= CW'(DEF_DIV);
      shadow_q  <= CW'(DEF_DIV);
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      clk_out_q <= IDLE_LVL;
    end else begin
      cnt_q     <= cnt_d;
      term_q    <= term_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_out_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - multi-channel programmable clock/strobe divider with double-buffered divisors
// Define CLKDIV_SYNC_EN to add the sync input that phase-aligns all channels.
module clk_div_bank import clkdiv_pkg::*; #(
  parameter int   CH       = 4,
  parameter int   CW       = 16,
  parameter int   DEF_DIV  = DEF_DIV_DFLT,
  parameter logic IDLE_LVL = IDLE_LVL_DFLT
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef CLKDIV_SYNC_EN
  input  logic                   sync,
`endif
  input  logic [CH-1:0]          en,
  input  logic                   div_wr,
  input  logic [sel_w(CH)-1:0]   div_sel,
  input  logic [CW-1:0]          div_data,
  output logic                   div_ack,
  output logic [CH-1:0]          pending,
  output logic [CH-1:0]          tick,
  output logic [CH-1:0]          clk_out
);

  localparam int SW = sel_w(CH);

  logic sync_w;
  logic div_ack_q;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  // Out-of-range selects match no channel but are still acknowledged.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    localparam logic [SW-1:0] IDX = SW'(i);
    clkdiv_ch #(
      .CW       (CW),
      .DEF_DIV  (DEF_DIV),
      .IDLE_LVL (IDLE_LVL)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en[i]),
      .sync_i    (sync_w),
      .wr_i      (div_wr && (div_sel == IDX)),
      .wr_data_i (div_data),
      .tick_o    (tick[i]),
      .clk_out_o (clk_out[i]),
      .pending_o (pending[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_ack_q <= 1'b0;
    else        div_ack_q <= div_wr;
  end

  assign div_ack = div_ack_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - directed self-checking bench for clk_div_bank
module tb_clk_div_bank;

  localparam int CH = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sync;
  logic [CH-1:0] en;
  logic          div_wr;
  logic [2:0]    div_sel;
  logic [CW-1:0] div_data;
  logic          div_ack;
  logic [CH-1:0] pending;
  logic [CH-1:0] tick;
  logic [CH-1:0] clk_out;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_div_bank #(
    .CH       (CH),
    .CW       (CW),
    .DEF_DIV  (3),
    .IDLE_LVL (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef CLKDIV_SYNC_EN
    .sync     (sync),
`endif
    .en       (en),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_data (div_data),
    .div_ack  (div_ack),
    .pending  (pending),
    .tick     (tick),
    .clk_out  (clk_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; en = '0;
    div_wr = 1'b0; div_sel = '0; div_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_clk", clk_out, 5'h1F);
    chk("rst_pend", pending, 0);
    chk("rst_ack", div_ack, 0);

    // default term 3 on ch0
    rst_n = 1'b1;
    en = 5'b00001;
    for (int s = 1; s <= 16; s++) begin
      step();
      chk("t1_tick", tick[0], (s % 4 == 0));
      chk("t1_clk", clk_out[0], ((s / 4) % 2 == 0));
    end
    chk("t1_idle_tick", tick[4:1], 0);
    chk("t1_idle_clk", clk_out[4:1], 4'hF);

    // write 9 to running ch0 mid-period
    step();
    chk("t2_pre_tick", tick[0], 0);
    div_wr = 1'b1; div_sel = 3'd0; div_data = 16'd9;
    step();
    chk("t2_pend_set", pending[0], 1);
    chk("t2_ack", div_ack, 1);
    div_wr = 1'b0;
    step();
    chk("t2_ack_off", div_ack, 0);
    chk("t2_pend_hold", pending[0], 1);
    chk("t2_old_tick", tick[0], 0);
    step();
    chk("t2_old_tick", tick[0], 1);
    chk("t2_pend_clr", pending[0], 0);
    chk("t2_clk_low", clk_out[0], 0);
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("t2_new_tick", tick[0], (j == 10));
    end
    chk("t2_clk_high", clk_out[0], 1);

    // write 0 to disabled ch1
    div_wr = 1'b1; div_sel = 3'd1; div_data = 16'd0;
    step();
    chk("t3_ack", div_ack, 1);
    chk("t3_pend", pending[1], 0);
    div_wr = 1'b0;
    en = 5'b00011;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("t3_tick", tick[1], 1);
      chk("t3_clk", clk_out[1], (j % 2 == 0));
      chk("t3_pend", pending[1], 0);
    end

    // two writes to ch2, last wins
    en = 5'b00111;
    step();
    div_wr = 1'b1; div_sel = 3'd2; div_data = 16'd5;
    step();
    chk("t4_pend", pending[2], 1);
    chk("t4_ack1", div_ack, 1);
    div_data = 16'd7;
    step();
    chk("t4_ack2", div_ack, 1);
    chk("t4_pend2", pending[2], 1);
    div_wr = 1'b0;
    step();
    chk("t4_tick_old", tick[2], 1);
    chk("t4_pend_clr", pending[2], 0);
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("t4_tick7", tick[2], (j == 8));
    end

    // out-of-range select
    div_wr = 1'b1; div_sel = 3'd5; div_data = 16'd1;
    step();
    chk("t4_oor_ack", div_ack, 1);
    chk("t4_oor_pend", pending, 0);
    chk("t4_oor_ch1", tick[1], 1);
    div_wr = 1'b0;

    // drop and restore enable on ch2
    step();
    en = 5'b00011;
    step();
    chk("t5_dis_clk", clk_out[2], 1);
    chk("t5_dis_tick", tick[2], 0);
    en = 5'b00111;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("t5_re_tick", tick[2], (j == 8));
      chk("t5_re_clk", clk_out[2], (j < 8));
    end

    // asynchronous reset mid-period
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_arst_tick", tick, 0);
    chk("t5_arst_clk", clk_out, 5'h1F);
    chk("t5_arst_pend", pending, 0);
    chk("t5_arst_ack", div_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 5'b00011;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("t5_def_tick0", tick[0], (j == 4));
      chk("t5_def_tick1", tick[1], (j == 4));
    end

`ifdef CLKDIV_SYNC_EN
    en = 5'b00001;
    div_wr = 1'b1; div_sel = 3'd1; div_data = 16'd7;
    step();
    div_wr = 1'b0;
    en = 5'b00011;
    step();
    step();
    sync = 1'b1;
    step();
    chk("t6_sync_clk", clk_out[1:0], 2'b11);
    chk("t6_sync_tick", tick[1:0], 0);
    sync = 1'b0;
    for (int s = 1; s <= 16; s++) begin
      step();
      chk("t6_tick0", tick[0], (s % 4 == 0));
      chk("t6_tick1", tick[1], (s % 8 == 0));
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
